// File: rtl/avmm_mmio_csr_responder_if.sv
// Avalon-MM bus bundle between the CCI-P MMIO bridge master and the AFU CSR
// responder.
//
// Handshake: a request (read or write) is accepted on a rising clk edge where
// the master holds read or write high and waitrequest is low. While
// waitrequest is high the master keeps the request and its address, data and
// byteenable stable. Each accepted read returns exactly one readdatavalid
// strobe, and responses arrive in request order. readdata is meaningful only
// while readdatavalid is high.
interface avmm_mmio_csr_responder_if #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 64
);
    logic                    waitrequest;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [ADDR_WIDTH-1:0]   address;
    logic                    write;
    logic                    read;
    logic [DATA_WIDTH/8-1:0] byteenable;

    modport master (
        input  waitrequest, readdata, readdatavalid,
        output writedata, address, write, read, byteenable
    );

    modport slave (
        output waitrequest, readdata, readdatavalid,
        input  writedata, address, write, read, byteenable
    );
endinterface

// File: rtl/avmm_mmio_csr_responder.sv
// AFU device-feature CSR responder on the MMIO Avalon-MM bus: DFH, AFU ID,
// scratch, control (run level + interrupt fire) and status registers.
// Read data is muxed when a read is accepted and delivered READ_LATENCY
// cycles later through a valid/data shift register.
// Optional build macro: CSR_TIMESTAMP_EN maps a free-running 64-bit cycle
// counter at offset 0x40; without it 0x40 reads as zero.
module avmm_mmio_csr_responder #(
    parameter int          ADDR_WIDTH   = 18,
    parameter int          DATA_WIDTH   = 64,
    parameter int          READ_LATENCY = 2,
    parameter logic [63:0] DFH_VALUE    = 64'h1000_0100_0000_0000,
    parameter logic [63:0] AFU_ID_L     = 64'h0,
    parameter logic [63:0] AFU_ID_H     = 64'h0
) (
    input  logic                            clk,
    input  logic                            reset,
    avmm_mmio_csr_responder_if.slave        avmm,
    output logic                            irq,
    output logic                            ctrl_run,
    input  logic [31:0]                     status_in
);
    localparam int WORD_WIDTH = ADDR_WIDTH - 3;
    localparam int NUM_BYTES  = DATA_WIDTH / 8;

    // 64-bit word offsets (byte offset >> 3)
    localparam logic [WORD_WIDTH-1:0] W_DFH     = WORD_WIDTH'(0);
    localparam logic [WORD_WIDTH-1:0] W_AFU_L   = WORD_WIDTH'(1);
    localparam logic [WORD_WIDTH-1:0] W_AFU_H   = WORD_WIDTH'(2);
    localparam logic [WORD_WIDTH-1:0] W_SCRATCH = WORD_WIDTH'(5);
    localparam logic [WORD_WIDTH-1:0] W_CTRL    = WORD_WIDTH'(6);
    localparam logic [WORD_WIDTH-1:0] W_STATUS  = WORD_WIDTH'(7);
`ifdef CSR_TIMESTAMP_EN
    localparam logic [WORD_WIDTH-1:0] W_TSTAMP  = WORD_WIDTH'(8);
`endif

    logic                    wait_q;
    logic [DATA_WIDTH-1:0]   scratch;
    logic [31:0]             irq_count;
    logic [WORD_WIDTH-1:0]   word;
    logic                    wr_accept;
    logic                    rd_accept;
    logic                    ctrl_wr;
    logic [DATA_WIDTH-1:0]   rd_mux;
    logic [READ_LATENCY-1:0] vld_pipe;
    logic [DATA_WIDTH-1:0]   data_pipe [READ_LATENCY];
    logic                    unused_addr_bits;
`ifdef CSR_TIMESTAMP_EN
    logic [63:0]             timestamp;
`endif

    assign word             = avmm.address[ADDR_WIDTH-1:3];
    assign unused_addr_bits = ^avmm.address[2:0];
    assign wr_accept        = avmm.write && !wait_q;
    // A read issued together with a write is dropped; the write wins.
    assign rd_accept        = avmm.read && !avmm.write && !wait_q;
    assign ctrl_wr          = wr_accept && (word == W_CTRL) && avmm.byteenable[0];

    assign avmm.waitrequest   = wait_q;
    assign avmm.readdatavalid = vld_pipe[READ_LATENCY-1];
    assign avmm.readdata      = data_pipe[READ_LATENCY-1];

    // Stall for one cycle after reset release, then accept forever.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wait_q <= 1'b1;
        else       wait_q <= 1'b0;
    end

    // Scratch register with per-byte write enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch <= '0;
        end else if (wr_accept && (word == W_SCRATCH)) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (avmm.byteenable[b]) scratch[8*b +: 8] <= avmm.writedata[8*b +: 8];
            end
        end
    end

    // CTRL: run level, one-cycle irq pulse and saturating fire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_run  <= 1'b0;
            irq       <= 1'b0;
            irq_count <= '0;
        end else begin
            irq <= 1'b0;
            if (ctrl_wr) begin
                ctrl_run <= avmm.writedata[0];
                if (avmm.writedata[1]) begin
                    irq <= 1'b1;
                    if (irq_count != 32'hFFFF_FFFF) irq_count <= irq_count + 32'd1;
                end
            end
        end
    end

`ifdef CSR_TIMESTAMP_EN
    // Free-running cycle counter, wraps naturally at 2^64.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) timestamp <= '0;
        else       timestamp <= timestamp + 64'd1;
    end
`endif

    // Read data selection in the accept cycle.
    always_comb begin
        rd_mux = '0;
        case (word)
            W_DFH:     rd_mux = DFH_VALUE;
            W_AFU_L:   rd_mux = AFU_ID_L;
            W_AFU_H:   rd_mux = AFU_ID_H;
            W_SCRATCH: rd_mux = scratch;
            W_CTRL:    rd_mux = {{(DATA_WIDTH-1){1'b0}}, ctrl_run};
            W_STATUS:  rd_mux = {irq_count, status_in};
`ifdef CSR_TIMESTAMP_EN
            W_TSTAMP:  rd_mux = timestamp;
`endif
            default:   rd_mux = '0;
        endcase
    end

    // Response shift register; each data stage only loads with a valid
    // entry so the output stage holds its last value between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            for (int i = 0; i < READ_LATENCY; i++) data_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= rd_accept;
            if (rd_accept) data_pipe[0] <= rd_mux;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) data_pipe[i] <= data_pipe[i-1];
            end
        end
    end
endmodule

// File: tb/tb_avmm_mmio_csr_responder.sv
// Self-checking bench for avmm_mmio_csr_responder: directed scenarios plus a
// randomized mix, checked against a register-map model and a response queue.
module tb_avmm_mmio_csr_responder;
  localparam int          AW    = 18;
  localparam int          RL    = 2;
  localparam logic [63:0] DFH   = 64'h1000_0100_0000_0000;
  localparam logic [63:0] AFU_L = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] AFU_H = 64'hFEDC_BA98_7654_3210;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        irq;
  logic        ctrl_run;
  logic [31:0] status_in = 32'h0;

  avmm_mmio_csr_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(64)) avmm ();

  avmm_mmio_csr_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(64), .READ_LATENCY(RL),
    .DFH_VALUE(DFH), .AFU_ID_L(AFU_L), .AFU_ID_H(AFU_H)
  ) dut (
    .clk(clk), .reset(reset), .avmm(avmm),
    .irq(irq), .ctrl_run(ctrl_run), .status_in(status_in)
  );

  // ---------------- clock / reset / counters ----------------
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int irq_hi = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (irq === 1'b1) irq_hi++;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [63:0] obs_q[$];
  int          obs_cyc_q[$];

  always @(negedge clk) begin
    if (avmm.readdatavalid === 1'b1) begin
      obs_q.push_back(avmm.readdata);
      obs_cyc_q.push_back(cyc);
    end
  end

  // ---------------- reference model ----------------
  logic [63:0] m_scratch;
  logic        m_run;
  logic [31:0] m_irq_count;

  function automatic void model_reset();
    m_scratch = 64'h0;
    m_run = 1'b0;
    m_irq_count = 32'h0;
  endfunction

  function automatic logic [63:0] model_read(input logic [AW-1:0] a);
    int unsigned off;
    off = {14'b0, a[AW-1:3], 3'b000};
    case (off)
      32'h00:  return DFH;
      32'h08:  return AFU_L;
      32'h10:  return AFU_H;
      32'h28:  return m_scratch;
      32'h30:  return {63'b0, m_run};
      32'h38:  return {m_irq_count, status_in};
      default: return 64'h0;
    endcase
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] be);
    int unsigned off;
    off = {14'b0, a[AW-1:3], 3'b000};
    if (off == 32'h28) begin
      for (int b = 0; b < 8; b++) if (be[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
    end else if (off == 32'h30 && be[0]) begin
      m_run = d[0];
      if (d[1] && m_irq_count != 32'hFFFF_FFFF) m_irq_count = m_irq_count + 1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_write(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] be);
    avmm.write = 1'b1; avmm.read = 1'b0;
    avmm.address = a; avmm.writedata = d; avmm.byteenable = be;
    @(posedge clk); #1;
    model_write(a, d, be);
  endtask

  task automatic drive_read(input logic [AW-1:0] a);
    logic [63:0] e;
    avmm.read = 1'b1; avmm.write = 1'b0; avmm.address = a;
    e = model_read(a);
    @(posedge clk); #1;
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + RL - 1);
  endtask

  task automatic idle(input int n);
    avmm.read = 1'b0; avmm.write = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int budget;
    idle(1);
    budget = 0;
    while (obs_q.size() < exp_q.size() && budget < 20) begin
      @(posedge clk); #1; budget++;
    end
    idle(RL + 2);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int w;
    w = $urandom_range(0, 9);
`ifdef CSR_TIMESTAMP_EN
    if (w == 8) w = 5;
`endif
    if (w == 9) w = $urandom_range(9, (1 << (AW - 3)) - 1);
    return AW'(w * 8 + $urandom_range(0, 7));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [63:0] e, o; int ec, oc;
    avmm.read = 1'b0; avmm.write = 1'b0; avmm.address = '0;
    avmm.writedata = '0; avmm.byteenable = '0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (avmm.waitrequest !== 1'b1) begin failed++; $display("FAIL rst_waitrequest: got %b required 1", avmm.waitrequest); end
    tests++; if (avmm.readdatavalid !== 1'b0) begin failed++; $display("FAIL rst_rdvalid: got %b required 0", avmm.readdatavalid); end
    tests++; if (avmm.readdata !== 64'h0) begin failed++; $display("FAIL rst_readdata: got %h required 0", avmm.readdata); end
    tests++; if (irq !== 1'b0) begin failed++; $display("FAIL rst_irq: got %b required 0", irq); end
    tests++; if (ctrl_run !== 1'b0) begin failed++; $display("FAIL rst_ctrl_run: got %b required 0", ctrl_run); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    // Read held from release; the stalled cycle must not accept it.
    avmm.read = 1'b1; avmm.address = 18'h00;
    @(negedge clk);
    tests++; if (avmm.waitrequest !== 1'b1) begin failed++; $display("FAIL post_rst_wait: got %b required 1", avmm.waitrequest); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if (avmm.waitrequest !== 1'b0) begin failed++; $display("FAIL post_rst_ready: got %b required 0", avmm.waitrequest); end
    drive_read(18'h00);
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL reset_dfh: no response, required %h at cycle %0d", e, ec); end
      else begin
        o = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
        if (o !== e || oc !== ec) begin failed++; $display("FAIL reset_dfh: got %h cycle %0d, required %h cycle %0d", o, oc, e, ec); end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin failed++; $display("FAIL reset_extra: got %0d extra responses, required 0", obs_q.size()); obs_q.delete(); obs_cyc_q.delete(); end
  endtask

  task automatic test_scratch();
    logic [63:0] e, o; int ec, oc;
    drive_write(18'h28, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    drive_write(18'h2B, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    drive_read(18'h28);
    for (int i = 0; i < 8; i++) begin
      drive_write(18'h28 + AW'($urandom_range(0, 7)), {$urandom, $urandom}, 8'($urandom));
      drive_read(18'h28);
    end
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL scratch_rd: no response, required %h at cycle %0d", e, ec); end
      else begin
        o = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
        if (o !== e || oc !== ec) begin failed++; $display("FAIL scratch_rd: got %h cycle %0d, required %h cycle %0d", o, oc, e, ec); end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin failed++; $display("FAIL scratch_extra: got %0d extra responses, required 0", obs_q.size()); obs_q.delete(); obs_cyc_q.delete(); end
  endtask

  task automatic test_ctrl_irq();
    logic [63:0] e, o; int ec, oc; int hi0;
    status_in = $urandom;
    drive_write(18'h30, 64'h3, 8'hFF);
    avmm.write = 1'b0;
    @(negedge clk);
    tests++; if (irq !== 1'b1) begin failed++; $display("FAIL irq_pulse: got %b required 1", irq); end
    tests++; if (ctrl_run !== 1'b1) begin failed++; $display("FAIL ctrl_run_set: got %b required 1", ctrl_run); end
    @(negedge clk);
    tests++; if (irq !== 1'b0) begin failed++; $display("FAIL irq_one_cycle: got %b required 0", irq); end
    @(posedge clk); #1;
    drive_read(18'h30);
    drive_read(18'h38);
    drain();
    // Two fire writes back to back, then a CTRL write without byteenable[0].
    hi0 = irq_hi;
    drive_write(18'h30, 64'h3, 8'h01);
    drive_write(18'h30, 64'h2, 8'h01);
    drive_write(18'h30, 64'h3, 8'hFE);
    idle(3);
    tests++; if (irq_hi - hi0 !== 2) begin failed++; $display("FAIL irq_double: got %0d pulse cycles required 2", irq_hi - hi0); end
    tests++; if (ctrl_run !== m_run) begin failed++; $display("FAIL ctrl_run_level: got %b required %b", ctrl_run, m_run); end
    drive_read(18'h30);
    drive_read(18'h38);
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL ctrl_rd: no response, required %h at cycle %0d", e, ec); end
      else begin
        o = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
        if (o !== e || oc !== ec) begin failed++; $display("FAIL ctrl_rd: got %h cycle %0d, required %h cycle %0d", o, oc, e, ec); end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin failed++; $display("FAIL ctrl_extra: got %0d extra responses, required 0", obs_q.size()); obs_q.delete(); obs_cyc_q.delete(); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e, o; int ec, oc;
    status_in = 32'hA5A5_0001;
    drive_read(18'h08);
    drive_read(18'h10);
    drive_read(18'h38);
    drive_read(18'h1F8);
    for (int i = 0; i < 16; i++) drive_read(pick_addr());
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL b2b_rd: no response, required %h at cycle %0d", e, ec); end
      else begin
        o = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
        if (o !== e || oc !== ec) begin failed++; $display("FAIL b2b_rd: got %h cycle %0d, required %h cycle %0d", o, oc, e, ec); end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin failed++; $display("FAIL b2b_extra: got %0d extra responses, required 0", obs_q.size()); obs_q.delete(); obs_cyc_q.delete(); end
  endtask

  task automatic test_rw_collision();
    logic [63:0] e, o; int ec, oc;
    avmm.read = 1'b1; avmm.write = 1'b1; avmm.address = 18'h28;
    avmm.writedata = 64'h5; avmm.byteenable = 8'hFF;
    @(posedge clk); #1;
    model_write(18'h28, 64'h5, 8'hFF);
    idle(RL + 3);
    tests++;
    if (obs_q.size() != 0) begin failed++; $display("FAIL collision_no_resp: got %0d responses required 0", obs_q.size()); obs_q.delete(); obs_cyc_q.delete(); end
    drive_read(18'h28);
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL collision_rd: no response, required %h at cycle %0d", e, ec); end
      else begin
        o = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
        if (o !== e || oc !== ec) begin failed++; $display("FAIL collision_rd: got %h cycle %0d, required %h cycle %0d", o, oc, e, ec); end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin failed++; $display("FAIL collision_extra: got %0d extra responses, required 0", obs_q.size()); obs_q.delete(); obs_cyc_q.delete(); end
  endtask

  task automatic test_random();
    logic [63:0] e, o; int ec, oc; int op;
    for (int i = 0; i < 300; i++) begin
      status_in = $urandom;
      op = $urandom_range(0, 7);
      if (op <= 3) drive_read(pick_addr());
      else if (op <= 6) drive_write(pick_addr(), {$urandom, $urandom}, 8'($urandom));
      else idle(1);
    end
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL random_rd: no response, required %h at cycle %0d", e, ec); end
      else begin
        o = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
        if (o !== e || oc !== ec) begin failed++; $display("FAIL random_rd: got %h cycle %0d, required %h cycle %0d", o, oc, e, ec); end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin failed++; $display("FAIL random_extra: got %0d extra responses, required 0", obs_q.size()); obs_q.delete(); obs_cyc_q.delete(); end
  endtask

  task automatic test_reset_mid_read();
    logic [63:0] e, o; int ec, oc;
    drive_write(18'h28, 64'hCAFE_F00D_1234_5678, 8'hFF);
    drive_write(18'h30, 64'h3, 8'h01);
    drive_read(18'h28);
    drain();
    exp_q.delete(); exp_cyc_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    avmm.read = 1'b1; avmm.address = 18'h28;
    @(posedge clk); #1;
    avmm.read = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    tests++; if (avmm.waitrequest !== 1'b1) begin failed++; $display("FAIL midrst_wait: got %b required 1", avmm.waitrequest); end
    tests++; if (avmm.readdata !== 64'h0) begin failed++; $display("FAIL midrst_readdata: got %h required 0", avmm.readdata); end
    tests++; if (ctrl_run !== 1'b0) begin failed++; $display("FAIL midrst_ctrl_run: got %b required 0", ctrl_run); end
    tests++; if (irq !== 1'b0) begin failed++; $display("FAIL midrst_irq: got %b required 0", irq); end
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    idle(RL + 4);
    tests++;
    if (obs_q.size() != 0) begin failed++; $display("FAIL midrst_dropped: got %0d responses required 0", obs_q.size()); obs_q.delete(); obs_cyc_q.delete(); end
    status_in = $urandom;
    drive_read(18'h28);
    drive_read(18'h38);
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL midrst_rd: no response, required %h at cycle %0d", e, ec); end
      else begin
        o = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
        if (o !== e || oc !== ec) begin failed++; $display("FAIL midrst_rd: got %h cycle %0d, required %h cycle %0d", o, oc, e, ec); end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin failed++; $display("FAIL midrst_extra: got %0d extra responses, required 0", obs_q.size()); obs_q.delete(); obs_cyc_q.delete(); end
  endtask

`ifdef CSR_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [63:0] t0, t1; int budget;
    obs_q.delete(); obs_cyc_q.delete();
    avmm.write = 1'b0; avmm.read = 1'b1; avmm.address = 18'h40;
    @(posedge clk); #1;
    avmm.read = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    avmm.read = 1'b1;
    @(posedge clk); #1;
    avmm.read = 1'b0;
    budget = 0;
    while (obs_q.size() < 2 && budget < 20) begin @(posedge clk); #1; budget++; end
    tests++;
    if (obs_q.size() != 2) begin
      failed++; $display("FAIL tstamp_resp: got %0d responses required 2", obs_q.size());
    end else begin
      t0 = obs_q.pop_front(); t1 = obs_q.pop_front();
      tests++;
      if (t1 - t0 !== 64'd10) begin failed++; $display("FAIL tstamp_delta: got %0d required 10", t1 - t0); end
    end
    obs_q.delete(); obs_cyc_q.delete();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_scratch();
    test_ctrl_irq();
    test_back_to_back();
    test_rw_collision();
    test_random();
    test_reset_mid_read();
`ifdef CSR_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
